// File: rtl/fp_spike_generator_if.sv
// Potential stream from the accumulating adder into the spike generator.
// The accumulator side drives potential/valid; the spike generator returns ready.
interface fp_spike_generator_if;
    logic [31:0] potential;
    logic        potential_valid;
    logic        potential_ready;

    modport master (
        output potential,
        output potential_valid,
        input  potential_ready
    );

    modport slave (
        input  potential,
        input  potential_valid,
        output potential_ready
    );
endinterface

// File: rtl/fp_spike_generator.sv
// FP32 threshold-and-fire stage with accumulator clear and refractory hold-off.
// Optional SPIKE_COUNTER_EN builds the saturating spike_count register; otherwise spike_count is 0.
module fp_spike_generator #(
    parameter logic [31:0] THRESHOLD         = 32'h3F80_0000,
    parameter int          REFRACTORY_CYCLES = 4,
    parameter int          COUNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fp_spike_generator_if.slave  bus,
    output logic                 spike,
    output logic                 acc_clear,
    output logic                 refractory,
    output logic                 fp_error,
    output logic [COUNT_W-1:0]   spike_count
);

    localparam int RC_W = (REFRACTORY_CYCLES > 1) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACTORY_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FIRE,
        REFRACT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       p_q;
    logic [RC_W-1:0]   rcnt;
    logic              is_special;
    logic              at_threshold;

    // Exponent all-ones covers both Inf and NaN; the magnitude compare works
    // directly on the bit pattern because positive finite FP32 values order as integers.
    assign is_special   = (p_q[30:23] == 8'hFF);
    assign at_threshold = (p_q[30:0] >= THRESHOLD[30:0]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.potential_valid) state_next = CHECK;
            end
            CHECK: begin
                if (is_special)        state_next = IDLE;
                else if (p_q[31])      state_next = IDLE;
                else if (at_threshold) state_next = FIRE;
                else                   state_next = IDLE;
            end
            FIRE: begin
                state_next = (REFRACTORY_CYCLES == 0) ? IDLE : REFRACT;
            end
            REFRACT: begin
                if (rcnt == RC_W'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs straight from the state register keep spike/acc_clear glitch-free.
    assign bus.potential_ready = (state == IDLE);
    assign spike               = (state == FIRE);
    assign acc_clear           = (state == FIRE);
    assign refractory          = (state == REFRACT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q      <= '0;
            rcnt     <= '0;
            fp_error <= 1'b0;
        end else begin
            if (state == IDLE && bus.potential_valid) p_q <= bus.potential;
            if (state == CHECK && is_special)         fp_error <= 1'b1;
            if (state == FIRE)                        rcnt <= RC_LOAD;
            else if (state == REFRACT)                rcnt <= rcnt - RC_W'(1);
        end
    end

`ifdef SPIKE_COUNTER_EN
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (state == FIRE && count_q != '1) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = '0;
`endif

endmodule

// File: tb/tb_fp_spike_generator.sv
// Scoreboard bench for fp_spike_generator: the driver pushes the expected outcome of each
// potential, a monitor pops it when the DUT resolves that potential and checks the outputs.
module tb_fp_spike_generator;

    localparam int R = 4;

`ifdef SPIKE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spike, acc_clear, refractory, fp_error;
    logic [15:0] spike_count;
    logic        spike2, acc_clear2, refractory2, fp_error2;
    logic [1:0]  spike_count2;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_spike_generator_if bus ();
    fp_spike_generator_if bus2 ();

    assign bus2.potential       = bus.potential;
    assign bus2.potential_valid = bus.potential_valid;

    fp_spike_generator #(.THRESHOLD(32'h3F80_0000), .REFRACTORY_CYCLES(R), .COUNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .spike       (spike),
        .acc_clear   (acc_clear),
        .refractory  (refractory),
        .fp_error    (fp_error),
        .spike_count (spike_count)
    );

    // Narrow-counter copy fed the same stream, used for the saturation check.
    fp_spike_generator #(.THRESHOLD(32'h3F80_0000), .REFRACTORY_CYCLES(R), .COUNT_W(2)) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus2),
        .spike       (spike2),
        .acc_clear   (acc_clear2),
        .refractory  (refractory2),
        .fp_error    (fp_error2),
        .spike_count (spike_count2)
    );

    typedef struct {
        bit fire;
        bit err;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t sb[$];
    bit   m_err  = 1'b0;
    int   m_cnt  = 0;
    int   m_cnt2 = 0;
    int   total  = 0;
    int   bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
        sb.delete();
    endtask

    // Called at posedge+1; returns the cycle number of the accepting edge.
    task automatic send(input logic [31:0] v, input bit fire, output int acc_cyc);
        exp_t e;
        bit   done;
        if (v[30:23] == 8'hFF) m_err = 1'b1;
        if (fire) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3)    m_cnt2++;
        end
        e.fire = fire;
        e.err  = m_err;
        e.cnt  = CNT_EN ? m_cnt : 0;
        e.cnt2 = CNT_EN ? m_cnt2 : 0;
        sb.push_back(e);
        bus.potential       = v;
        bus.potential_valid = 1'b1;
        done    = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.potential_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                done    = 1'b1;
            end
        end
        bus.potential_valid = 1'b0;
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
            void'(sb.pop_back());
        end
    endtask

    // Monitor: detects each transfer, then checks CHECK, FIRE/IDLE and the refractory window.
    initial begin
        exp_t e;
        bit   skip;
        bit   aborted;
        bit   leave;
        int   n;
        skip = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (!reset_n) continue;
            if (!(bus.potential_valid && bus.potential_ready)) continue;
            @(negedge clk);
            if (!reset_n) continue;
            check("check_ready", bus.potential_ready, 1'b0);
            check("check_spike", spike, 1'b0);
            @(negedge clk);
            if (!reset_n) continue;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
                continue;
            end
            e = sb.pop_front();
            check("spike", spike, e.fire);
            check("acc_clear", acc_clear, e.fire);
            check("spike_w2", spike2, e.fire);
            check("fp_error", fp_error, e.err);
            if (e.fire) begin
                check("fire_ready", bus.potential_ready, 1'b0);
                n       = 0;
                aborted = 1'b0;
                leave   = 1'b0;
                for (int i = 0; i < 32 && !leave; i++) begin
                    @(negedge clk);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        leave   = 1'b1;
                    end else if (!refractory) begin
                        leave = 1'b1;
                    end else begin
                        n++;
                        check("refr_ready", bus.potential_ready, 1'b0);
                    end
                end
                if (!aborted) begin
                    check("refr_len", n, R);
                    check("ready_back", bus.potential_ready, 1'b1);
                    check("spike_after", spike, 1'b0);
                    check("spike_count", spike_count, e.cnt);
                    check("spike_count_w2", spike_count2, e.cnt2);
                    skip = 1'b1;
                end
            end else begin
                check("nofire_ready", bus.potential_ready, 1'b1);
                check("spike_count", spike_count, e.cnt);
                check("spike_count_w2", spike_count2, e.cnt2);
                skip = 1'b1;
            end
        end
    end

    logic [31:0] vals  [9] = '{32'hC000_0000, 32'h7F80_0000, 32'h3F00_0000, 32'h7FC0_0000,
                               32'h8000_0000, 32'h0000_0001, 32'h3F7F_FFFF, 32'h7F7F_FFFF,
                               32'h3FC0_0000};
    bit          fires [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int a, b;
        bus.potential       = '0;
        bus.potential_valid = 1'b0;
        reset_n             = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.potential_ready, 1'b1);
        check("rst_spike", spike, 1'b0);
        check("rst_acc_clear", acc_clear, 1'b0);
        check("rst_refractory", refractory, 1'b0);
        check("rst_fp_error", fp_error, 1'b0);
        check("rst_spike_count", spike_count, 32'd0);
        @(posedge clk);
        #1;

        // Sub-threshold back-to-back: one-cycle CHECK, accept every second edge.
        send(32'h3F00_0000, 1'b0, a);
        send(32'h3F00_0000, 1'b0, b);
        check("subthr_gap", b - a, 2);

        // Fire at exactly threshold, second potential held through FIRE/REFRACT.
        send(32'h3F80_0000, 1'b1, a);
        send(32'h3F80_0000, 1'b1, b);
        check("refr_gap", b - a, R + 3);

        // Signs, specials, denormal and boundary magnitudes.
        for (int i = 0; i < 9; i++) send(vals[i], fires[i], a);

        // Reset during the second REFRACT cycle.
        send(32'h3F80_0000, 1'b1, a);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_ready", bus.potential_ready, 1'b1);
        check("midrst_refractory", refractory, 1'b0);
        check("midrst_spike", spike, 1'b0);
        check("midrst_fp_error", fp_error, 1'b0);
        check("midrst_spike_count", spike_count, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Five fires of 2.0 after reset: wide counter reaches 5, 2-bit counter sticks at 3.
        for (int i = 0; i < 5; i++) send(32'h4000_0000, 1'b1, a);

        repeat (R + 10) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
